// File: rtl/parking_gate_controller.sv
// Multi-lane parking gate controller: round-robin entry/exit arbitration against a
// runtime capacity, registered occupancy count and a fixed-length gate timer per lane.
module parking_gate_controller #(
    parameter int N_ENTRY     = 2,
    parameter int N_EXIT      = 2,
    parameter int CAP_W       = 8,
    parameter int GATE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_ENTRY-1:0] entry_req,
    input  logic [N_EXIT-1:0]  exit_req,
    input  logic [CAP_W-1:0]   capacity,
    output logic [N_ENTRY-1:0] entry_grant,
    output logic [N_EXIT-1:0]  exit_grant,
    output logic [N_ENTRY-1:0] entry_gate_open,
    output logic [N_EXIT-1:0]  exit_gate_open,
    output logic [CAP_W-1:0]   occupancy,
    output logic [CAP_W-1:0]   free_spaces,
    output logic               full
);

    localparam int EP_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int XP_W = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;
    localparam int TW   = $clog2(GATE_CYCLES + 1);

    logic [EP_W-1:0]    entry_ptr, entry_win, entry_ptr_nxt;
    logic [XP_W-1:0]    exit_ptr, exit_win, exit_ptr_nxt;
    logic               entry_found, exit_found, entry_go, exit_go;
    logic [N_ENTRY-1:0] entry_elig, entry_grant_nxt;
    logic [N_EXIT-1:0]  exit_elig, exit_grant_nxt;
    logic [TW-1:0]      entry_timer [N_ENTRY];
    logic [TW-1:0]      exit_timer  [N_EXIT];

    assign full        = (occupancy >= capacity);
    assign free_spaces = full ? '0 : (capacity - occupancy);

    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) begin
            entry_gate_open[i] = (entry_timer[i] != '0);
        end
    end

    always_comb begin
        for (int i = 0; i < N_EXIT; i++) begin
            exit_gate_open[i] = (exit_timer[i] != '0);
        end
    end

    // Entry arbitration: first eligible lane at or above the pointer, wrapping.
    always_comb begin
        entry_elig      = entry_req & ~entry_gate_open;
        entry_found     = 1'b0;
        entry_win       = '0;
        entry_grant_nxt = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (!entry_found && entry_elig[(int'(entry_ptr) + i) % N_ENTRY]) begin
                entry_found = 1'b1;
                entry_win   = EP_W'((int'(entry_ptr) + i) % N_ENTRY);
            end
        end
        entry_go = entry_found && (occupancy < capacity);
        if (entry_go) begin
            entry_grant_nxt[entry_win] = 1'b1;
        end
        entry_ptr_nxt = (int'(entry_win) == N_ENTRY - 1) ? '0 : entry_win + EP_W'(1);
    end

    always_comb begin
        exit_elig      = exit_req & ~exit_gate_open;
        exit_found     = 1'b0;
        exit_win       = '0;
        exit_grant_nxt = '0;
        for (int i = 0; i < N_EXIT; i++) begin
            if (!exit_found && exit_elig[(int'(exit_ptr) + i) % N_EXIT]) begin
                exit_found = 1'b1;
                exit_win   = XP_W'((int'(exit_ptr) + i) % N_EXIT);
            end
        end
        exit_go = exit_found && (occupancy != '0);
        if (exit_go) begin
            exit_grant_nxt[exit_win] = 1'b1;
        end
        exit_ptr_nxt = (int'(exit_win) == N_EXIT - 1) ? '0 : exit_win + XP_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_grant <= '0;
            exit_grant  <= '0;
            entry_ptr   <= '0;
            exit_ptr    <= '0;
            occupancy   <= '0;
        end else begin
            entry_grant <= entry_grant_nxt;
            exit_grant  <= exit_grant_nxt;
            if (entry_go) begin
                entry_ptr <= entry_ptr_nxt;
            end
            if (exit_go) begin
                exit_ptr <= exit_ptr_nxt;
            end
            // Simultaneous entry and exit cancel out.
            if (entry_go && !exit_go) begin
                occupancy <= occupancy + CAP_W'(1);
            end else if (exit_go && !entry_go) begin
                occupancy <= occupancy - CAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                entry_timer[i] <= '0;
            end
            for (int i = 0; i < N_EXIT; i++) begin
                exit_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRY; i++) begin
                if (entry_grant_nxt[i]) begin
                    entry_timer[i] <= TW'(GATE_CYCLES);
                end else if (entry_timer[i] != '0) begin
                    entry_timer[i] <= entry_timer[i] - TW'(1);
                end
            end
            for (int i = 0; i < N_EXIT; i++) begin
                if (exit_grant_nxt[i]) begin
                    exit_timer[i] <= TW'(GATE_CYCLES);
                end else if (exit_timer[i] != '0) begin
                    exit_timer[i] <= exit_timer[i] - TW'(1);
                end
            end
        end
    end

endmodule
